// File: rtl/byte_pack_lanes.sv
// Packs a val/rdy byte stream into NBYTES-wide words with a per-lane enable mask.
// Define BYTE_PACK_BIG_ENDIAN_EN to place the first byte of each word in the most significant lane.
module byte_pack_lanes #(
    parameter int unsigned NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_val,
    output logic                  in_rdy,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [8*NBYTES-1:0]   out_data,
    output logic [NBYTES-1:0]     out_en
);

    localparam int unsigned DW = 8 * NBYTES;
    localparam int unsigned CW = $clog2(NBYTES);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [DW-1:0]     r_acc;
    logic [DW-1:0]     w_acc_nxt;
    logic [NBYTES-1:0] r_acc_mask;
    logic [NBYTES-1:0] w_acc_mask_nxt;
    logic [DW-1:0]     r_obuf;
    logic [DW-1:0]     w_obuf_nxt;
    logic [NBYTES-1:0] r_obuf_en;
    logic [NBYTES-1:0] w_obuf_en_nxt;
    logic              r_out_val;
    logic              w_out_val_nxt;

    logic              w_in_rdy;
    logic              w_in_xfer;
    logic              w_emit;
    logic [CW-1:0]     w_lane;
    logic [DW-1:0]     w_acc_new;
    logic [NBYTES-1:0] w_mask_new;

    // Lane selection and the word as it would look with the incoming byte merged in
    always_comb begin
`ifdef BYTE_PACK_BIG_ENDIAN_EN
        w_lane = CW'(NBYTES - 1) - r_cnt;
`else
        w_lane = r_cnt;
`endif
        w_acc_new  = r_acc | (DW'(in_data) << {w_lane, 3'b000});
        w_mask_new = r_acc_mask | (NBYTES'(1) << w_lane);
        w_in_rdy   = !r_out_val || out_rdy;
        w_in_xfer  = in_val && w_in_rdy;
        w_emit     = w_in_xfer && ((r_cnt == CW'(NBYTES - 1)) || in_last);
    end

    // Next-state, accumulator and output-buffer update
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_acc_nxt      = r_acc;
        w_acc_mask_nxt = r_acc_mask;
        w_obuf_nxt     = r_obuf;
        w_obuf_en_nxt  = r_obuf_en;
        w_out_val_nxt  = r_out_val;

        if (r_out_val && out_rdy) begin
            w_out_val_nxt = 1'b0;
        end

        if (w_emit) begin
            w_obuf_nxt     = w_acc_new;
            w_obuf_en_nxt  = w_mask_new;
            w_out_val_nxt  = 1'b1;
            w_acc_nxt      = '0;
            w_acc_mask_nxt = '0;
            w_cnt_nxt      = '0;
        end else if (w_in_xfer) begin
            w_acc_nxt      = w_acc_new;
            w_acc_mask_nxt = w_mask_new;
            w_cnt_nxt      = r_cnt + CW'(1);
        end

        case (r_state)
            S_IDLE:  if (w_in_xfer && !w_emit) w_state_nxt = S_ACCUM;
            S_ACCUM: if (w_emit)               w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_acc_mask <= '0;
            r_obuf     <= '0;
            r_obuf_en  <= '0;
            r_out_val  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_acc      <= w_acc_nxt;
            r_acc_mask <= w_acc_mask_nxt;
            r_obuf     <= w_obuf_nxt;
            r_obuf_en  <= w_obuf_en_nxt;
            r_out_val  <= w_out_val_nxt;
        end
    end

    assign in_rdy   = w_in_rdy;
    assign out_val  = r_out_val;
    assign out_data = r_obuf;
    assign out_en   = r_obuf_en;

endmodule

// File: tb/tb_byte_pack_lanes.sv
// Directed bench for byte_pack_lanes at NBYTES=2; honours BYTE_PACK_BIG_ENDIAN_EN for expected lane order.
module tb_byte_pack_lanes;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_val;
    logic        in_rdy;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_val;
    logic        out_rdy;
    logic [15:0] out_data;
    logic [1:0]  out_en;

    int n_cmp = 0;
    int n_err = 0;

    byte_pack_lanes #(.NBYTES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_en   (out_en)
    );

    always #5 clk = ~clk;

    // Expected packing of two bytes (a first, b second) and of a lone first byte
`ifdef BYTE_PACK_BIG_ENDIAN_EN
    function automatic logic [15:0] w2(input logic [7:0] a, input logic [7:0] b);
        return {a, b};
    endfunction
    function automatic logic [15:0] w1(input logic [7:0] a);
        return {a, 8'h00};
    endfunction
    localparam logic [1:0] EN1 = 2'b10;
`else
    function automatic logic [15:0] w2(input logic [7:0] a, input logic [7:0] b);
        return {b, a};
    endfunction
    function automatic logic [15:0] w1(input logic [7:0] a);
        return {8'h00, a};
    endfunction
    localparam logic [1:0] EN1 = 2'b01;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        in_val  = 1'b1;
        in_data = d;
        in_last = last;
        step();
        in_val  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_val = 1'b0; in_data = '0; in_last = 1'b0; out_rdy = 1'b1;
        step(); step();
        n_cmp++; if (out_val !== 1'b0)   begin n_err++; $display("FAIL reset_val got %b want 0", out_val); end
        n_cmp++; if (out_data !== 16'h0) begin n_err++; $display("FAIL reset_data got %h want 0000", out_data); end
        n_cmp++; if (out_en !== 2'b00)   begin n_err++; $display("FAIL reset_en got %b want 00", out_en); end
        n_cmp++; if (in_rdy !== 1'b1)    begin n_err++; $display("FAIL reset_rdy got %b want 1", in_rdy); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_word();
        out_rdy = 1'b1;
        send(8'h11, 1'b0);
        n_cmp++; if (out_val !== 1'b0) begin n_err++; $display("FAIL single_early got %b want 0", out_val); end
        send(8'h22, 1'b0);
        n_cmp++; if (out_val !== 1'b1) begin n_err++; $display("FAIL single_val got %b want 1", out_val); end
        n_cmp++; if (out_data !== w2(8'h11, 8'h22)) begin n_err++; $display("FAIL single_data got %h want %h", out_data, w2(8'h11, 8'h22)); end
        n_cmp++; if (out_en !== 2'b11) begin n_err++; $display("FAIL single_en got %b want 11", out_en); end
        step();
        n_cmp++; if (out_val !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", out_val); end
    endtask

    task automatic test_partial();
        out_rdy = 1'b1;
        send(8'hAB, 1'b1);
        n_cmp++; if (out_val !== 1'b1) begin n_err++; $display("FAIL partial_val got %b want 1", out_val); end
        n_cmp++; if (out_data !== w1(8'hAB)) begin n_err++; $display("FAIL partial_data got %h want %h", out_data, w1(8'hAB)); end
        n_cmp++; if (out_en !== EN1) begin n_err++; $display("FAIL partial_en got %b want %b", out_en, EN1); end
        step();
        n_cmp++; if (out_val !== 1'b0) begin n_err++; $display("FAIL partial_drain got %b want 0", out_val); end
    endtask

    task automatic test_backpressure();
        out_rdy = 1'b0;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL bp_rdy got %b want 0", in_rdy); end
        in_val = 1'b1; in_data = 8'h99; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (out_val !== 1'b1) begin n_err++; $display("FAIL bp_hold_val[%0d] got %b want 1", i, out_val); end
            n_cmp++; if (out_data !== w2(8'h11, 8'h22) || out_en !== 2'b11)
                begin n_err++; $display("FAIL bp_hold[%0d] got %h/%b want %h/11", i, out_data, out_en, w2(8'h11, 8'h22)); end
            n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL bp_rdy[%0d] got %b want 0", i, in_rdy); end
        end
        in_val = 1'b0; in_last = 1'b0; out_rdy = 1'b1;
        #1;
        n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL bp_release_rdy got %b want 1", in_rdy); end
        step();
        n_cmp++; if (out_val !== 1'b0) begin n_err++; $display("FAIL bp_consumed got %b want 0", out_val); end
        // The ignored 0x99 must not have advanced the lane counter
        send(8'h33, 1'b1);
        n_cmp++; if (out_data !== w1(8'h33) || out_en !== EN1)
            begin n_err++; $display("FAIL bp_ignored got %h/%b want %h/%b", out_data, out_en, w1(8'h33), EN1); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b = 8'(i + 1);
            in_val = 1'b1; in_data = b; in_last = 1'b0;
            #1;
            n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL stream_rdy[%0d] got %b want 1", i, in_rdy); end
            step();
            if (i % 2 == 1) begin
                n_cmp++; if (out_val !== 1'b1 || out_data !== w2(b - 8'd1, b) || out_en !== 2'b11)
                    begin n_err++; $display("FAIL stream_word[%0d] got %b/%h/%b want 1/%h/11", i, out_val, out_data, out_en, w2(b - 8'd1, b)); end
            end else begin
                n_cmp++; if (out_val !== 1'b0) begin n_err++; $display("FAIL stream_gap[%0d] got %b want 0", i, out_val); end
            end
        end
        in_val = 1'b0;
        step();
        n_cmp++; if (out_val !== 1'b0) begin n_err++; $display("FAIL stream_end got %b want 0", out_val); end
    endtask

    task automatic test_reset_mid();
        out_rdy = 1'b1;
        send(8'h55, 1'b0);
        reset = 1'b1; in_val = 1'b1; in_data = 8'hEE; in_last = 1'b1;
        #1;
        n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL rst_mid_rdy got %b want 1", in_rdy); end
        step();
        reset = 1'b0; in_val = 1'b0; in_last = 1'b0;
        n_cmp++; if (out_val !== 1'b0 || out_en !== 2'b00)
            begin n_err++; $display("FAIL rst_mid_clear got %b/%b want 0/00", out_val, out_en); end
        send(8'h66, 1'b0);
        n_cmp++; if (out_val !== 1'b0) begin n_err++; $display("FAIL rst_mid_early got %b want 0", out_val); end
        send(8'h77, 1'b0);
        n_cmp++; if (out_val !== 1'b1 || out_data !== w2(8'h66, 8'h77) || out_en !== 2'b11)
            begin n_err++; $display("FAIL rst_mid_word got %b/%h/%b want 1/%h/11", out_val, out_data, out_en, w2(8'h66, 8'h77)); end
        step();
    endtask

    task automatic test_odd_packet();
        out_rdy = 1'b1;
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        n_cmp++; if (out_val !== 1'b1 || out_data !== w2(8'hA1, 8'hA2) || out_en !== 2'b11)
            begin n_err++; $display("FAIL odd_w0 got %b/%h/%b want 1/%h/11", out_val, out_data, out_en, w2(8'hA1, 8'hA2)); end
        send(8'hA3, 1'b1);
        n_cmp++; if (out_val !== 1'b1 || out_data !== w1(8'hA3) || out_en !== EN1)
            begin n_err++; $display("FAIL odd_w1 got %b/%h/%b want 1/%h/%b", out_val, out_data, out_en, w1(8'hA3), EN1); end
        step();
        n_cmp++; if (out_val !== 1'b0) begin n_err++; $display("FAIL odd_drain got %b want 0", out_val); end
    endtask

    task automatic test_full_last();
        out_rdy = 1'b1;
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b1);
        n_cmp++; if (out_val !== 1'b1 || out_data !== w2(8'hC1, 8'hC2) || out_en !== 2'b11)
            begin n_err++; $display("FAIL full_last got %b/%h/%b want 1/%h/11", out_val, out_data, out_en, w2(8'hC1, 8'hC2)); end
        step();
        n_cmp++; if (out_val !== 1'b0) begin n_err++; $display("FAIL full_last_noextra got %b want 0", out_val); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_partial();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_odd_packet();
        test_full_last();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
